// File: rtl/axis_frame_gen_pkg.sv
// Shared types and default widths for the AXI-stream frame generator.
package axis_frame_gen_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-stream test frame generator: counting payload, configurable frame length,
// inter-frame gap, frame count, error-marked frame and early abort.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [LEN_WIDTH-1:0]  cfg_gap,
    input  logic [CNT_WIDTH-1:0]  cfg_frames,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic                  cfg_err_en,
    input  logic [CNT_WIDTH-1:0]  cfg_err_idx,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

    state_t                state_r;
    logic [DATA_WIDTH-1:0] tdata_r;
    logic                  tvalid_r;
    logic                  tlast_r;
    logic                  tuser_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  abort_pend_r;
    logic [CNT_WIDTH-1:0]  frames_sent_r;
    logic [LEN_WIDTH-1:0]  beat_cnt_r;
    logic [LEN_WIDTH-1:0]  gap_cnt_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  gap_r;
    logic [CNT_WIDTH-1:0]  frames_r;
    logic                  err_en_r;
    logic [CNT_WIDTH-1:0]  err_idx_r;

    logic                  xfer_s;
    logic                  abort_now_s;
    logic [CNT_WIDTH-1:0]  frames_inc_s;
    logic [LEN_WIDTH-1:0]  beat_inc_s;
    logic [LEN_WIDTH-1:0]  len_last_s;
    logic [LEN_WIDTH-1:0]  start_len_s;
    logic                  run_end_s;
    logic                  single_beat_s;
    logic                  err_cur_frame_s;
    logic                  err_next_frame_s;

    assign xfer_s           = tvalid_r & output_axis_tready;
    assign abort_now_s      = abort | abort_pend_r;
    assign frames_inc_s     = frames_sent_r + CNT_WIDTH'(1);
    assign beat_inc_s       = beat_cnt_r + LEN_WIDTH'(1);
    assign len_last_s       = len_r - LEN_WIDTH'(1);
    assign run_end_s        = (frames_r != {CNT_WIDTH{1'b0}}) && (frames_inc_s == frames_r);
    assign single_beat_s    = (len_r == LEN_WIDTH'(1));
    assign err_cur_frame_s  = err_en_r && (frames_sent_r == err_idx_r);
    assign err_next_frame_s = err_en_r && (frames_inc_s == err_idx_r);

    // A zero frame length is treated as a single-beat frame.
    always_comb begin
        start_len_s = cfg_len;
        if (cfg_len == {LEN_WIDTH{1'b0}}) begin
            start_len_s = LEN_WIDTH'(1);
        end else begin
            start_len_s = cfg_len;
        end
    end

    // Run control FSM; every stream and status output is registered here.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_r       <= ST_IDLE;
            tdata_r       <= {DATA_WIDTH{1'b0}};
            tvalid_r      <= 1'b0;
            tlast_r       <= 1'b0;
            tuser_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            abort_pend_r  <= 1'b0;
            frames_sent_r <= {CNT_WIDTH{1'b0}};
            beat_cnt_r    <= {LEN_WIDTH{1'b0}};
            gap_cnt_r     <= {LEN_WIDTH{1'b0}};
            len_r         <= {LEN_WIDTH{1'b0}};
            gap_r         <= {LEN_WIDTH{1'b0}};
            frames_r      <= {CNT_WIDTH{1'b0}};
            err_en_r      <= 1'b0;
            err_idx_r     <= {CNT_WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r         <= start_len_s;
                        gap_r         <= cfg_gap;
                        frames_r      <= cfg_frames;
                        err_en_r      <= cfg_err_en;
                        err_idx_r     <= cfg_err_idx;
                        tdata_r       <= cfg_seed;
                        frames_sent_r <= {CNT_WIDTH{1'b0}};
                        beat_cnt_r    <= {LEN_WIDTH{1'b0}};
                        abort_pend_r  <= 1'b0;
                        tvalid_r      <= 1'b1;
                        tlast_r       <= (start_len_s == LEN_WIDTH'(1));
                        tuser_r       <= (start_len_s == LEN_WIDTH'(1)) && cfg_err_en &&
                                         (cfg_err_idx == {CNT_WIDTH{1'b0}});
                        busy_r        <= 1'b1;
                        state_r       <= ST_SEND;
                    end else begin
                        tvalid_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        tdata_r <= tdata_r + DATA_WIDTH'(1);
                        if (tlast_r) begin
                            frames_sent_r <= frames_inc_s;
                            beat_cnt_r    <= {LEN_WIDTH{1'b0}};
                            abort_pend_r  <= 1'b0;
                            if (abort_now_s || run_end_s) begin
                                tvalid_r <= 1'b0;
                                tlast_r  <= 1'b0;
                                tuser_r  <= 1'b0;
                                busy_r   <= 1'b0;
                                done_r   <= 1'b1;
                                state_r  <= ST_IDLE;
                            end else if (gap_r != {LEN_WIDTH{1'b0}}) begin
                                tvalid_r  <= 1'b0;
                                tlast_r   <= 1'b0;
                                tuser_r   <= 1'b0;
                                gap_cnt_r <= {LEN_WIDTH{1'b0}};
                                state_r   <= ST_GAP;
                            end else begin
                                tlast_r <= single_beat_s;
                                tuser_r <= single_beat_s && err_next_frame_s;
                            end
                        end else begin
                            beat_cnt_r <= beat_inc_s;
                            // Abort closes the frame with one extra errored tlast beat.
                            if (abort_now_s) begin
                                tlast_r      <= 1'b1;
                                tuser_r      <= 1'b1;
                                abort_pend_r <= 1'b1;
                            end else begin
                                tlast_r <= (beat_inc_s == len_last_s);
                                tuser_r <= (beat_inc_s == len_last_s) && err_cur_frame_s;
                            end
                        end
                    end else if (abort) begin
                        abort_pend_r <= 1'b1;
                    end else begin
                        abort_pend_r <= abort_pend_r;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (gap_cnt_r == (gap_r - LEN_WIDTH'(1))) begin
                        tvalid_r   <= 1'b1;
                        beat_cnt_r <= {LEN_WIDTH{1'b0}};
                        tlast_r    <= single_beat_s;
                        tuser_r    <= single_beat_s && err_cur_frame_s;
                        state_r    <= ST_SEND;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + LEN_WIDTH'(1);
                    end
                end
                default: begin
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                    tuser_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign output_axis_tdata  = tdata_r;
    assign output_axis_tvalid = tvalid_r;
    assign output_axis_tlast  = tlast_r;
    assign output_axis_tuser  = tuser_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign frames_sent        = frames_sent_r;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: randomized runs scored against a
// beat-list reference model built from the frame/abort rules.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        start;
    logic        abort;
    logic [15:0] cfg_len;
    logic [15:0] cfg_gap;
    logic [15:0] cfg_frames;
    logic [7:0]  cfg_seed;
    logic        cfg_err_en;
    logic [15:0] cfg_err_idx;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  got_q[$];
    logic [9:0]  exp_q[$];
    int          done_cnt;
    int          low_cnt;
    int          hold_err;
    bit          timed_out;
    int          exp_frames;

    axis_frame_gen dut (
        .clk                (clk),
        .async_rst_n        (async_rst_n),
        .start              (start),
        .abort              (abort),
        .cfg_len            (cfg_len),
        .cfg_gap            (cfg_gap),
        .cfg_frames         (cfg_frames),
        .cfg_seed           (cfg_seed),
        .cfg_err_en         (cfg_err_en),
        .cfg_err_idx        (cfg_err_idx),
        .output_axis_tdata  (tdata),
        .output_axis_tvalid (tvalid),
        .output_axis_tready (tready),
        .output_axis_tlast  (tlast),
        .output_axis_tuser  (tuser),
        .busy               (busy),
        .done               (done),
        .frames_sent        (frames_sent)
    );

    always #5 clk = ~clk;

    // Expected beat list {tuser,tlast,tdata}; abort_at = global index of the beat presented when abort hits.
    task automatic model_run(input int len, input int frames, input logic [7:0] seed,
                             input bit err_en, input int err_idx, input int abort_at);
        int L;
        int total;
        logic [7:0] d;
        bit last;
        bit user;
        exp_q.delete();
        L = (len == 0) ? 1 : len;
        total = (abort_at < 0) ? L * frames : abort_at + 1;
        for (int n = 0; n < total; n++) begin
            d    = seed + 8'(n);
            last = ((n % L) == L - 1);
            user = last && err_en && ((n / L) == err_idx);
            exp_q.push_back({user, last, d});
        end
        if (abort_at >= 0 && (abort_at % L) != L - 1) begin
            d = seed + 8'(abort_at + 1);
            exp_q.push_back({1'b1, 1'b1, d});
        end
        exp_frames = (abort_at < 0) ? frames : (abort_at / L) + 1;
    endtask

    task automatic do_start(input int len, input int gap, input int frames,
                            input logic [7:0] seed, input bit err_en, input int err_idx);
        cfg_len     = 16'(len);
        cfg_gap     = 16'(gap);
        cfg_frames  = 16'(frames);
        cfg_seed    = seed;
        cfg_err_en  = err_en;
        cfg_err_idx = 16'(err_idx);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        cfg_len     = 16'($urandom);
        cfg_gap     = 16'($urandom);
        cfg_frames  = 16'($urandom);
        cfg_seed    = 8'($urandom);
        cfg_err_en  = 1'($urandom);
        cfg_err_idx = 16'($urandom);
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random. abort_at: -1 none, -2 first gap cycle.
    task automatic collect(input int budget, input int ready_mode, input int abort_at);
        int tail;
        bit aborted;
        bit prev_stall;
        logic [9:0] prev_beat;
        got_q.delete();
        done_cnt = 0; low_cnt = 0; hold_err = 0; timed_out = 1'b0;
        aborted = 1'b0; prev_stall = 1'b0; prev_beat = 10'd0; tail = -1;
        for (int cyc = 0; cyc < budget && tail != 0; cyc++) begin
            case (ready_mode)
                0: tready = 1'b1;
                1: tready = ((cyc % 2) == 0);
                default: tready = ($urandom_range(0, 2) != 0);
            endcase
            abort = 1'b0;
            if (abort_at >= 0 && !aborted && tvalid && got_q.size() == abort_at) begin
                abort = 1'b1; aborted = 1'b1;
            end
            if (abort_at == -2 && !aborted && busy && !tvalid) begin
                abort = 1'b1; aborted = 1'b1;
            end
            if (prev_stall && (!tvalid || {tuser, tlast, tdata} !== prev_beat)) hold_err++;
            if (done) begin
                done_cnt++;
                if (tail < 0) tail = 3;
            end
            if (busy && !tvalid) low_cnt++;
            if (tvalid && tready) got_q.push_back({tuser, tlast, tdata});
            prev_stall = tvalid && !tready;
            prev_beat  = {tuser, tlast, tdata};
            @(negedge clk);
            if (tail > 0) tail--;
        end
        abort  = 1'b0;
        tready = 1'b1;
        if (tail != 0) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        async_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", tvalid); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", tlast); end
        checks++; if (tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser got %b want 0", tuser); end
        checks++; if (tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %h want 00", tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL rst_frames got %0d want 0", frames_sent); end
        async_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_idle_tvalid got %b want 0", tvalid); end
    endtask

    task automatic test_basic(input int mode, input string nm);
        model_run(4, 2, 8'hFE, 1'b0, 0, -1);
        do_start(4, 2, 2, 8'hFE, 1'b0, 0);
        collect(200, mode, -1);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL %s_timeout got 1 want 0", nm); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count got %0d want %0d", nm, got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_beat%0d got %h want %h", nm, i, got_q[i], exp_q[i]); end
        end
        checks++; if (low_cnt != 2) begin errors++; $display("FAIL %s_gap got %0d want 2", nm, low_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done got %0d want 1", nm, done_cnt); end
        checks++; if (frames_sent !== 16'd2) begin errors++; $display("FAIL %s_frames got %0d want 2", nm, frames_sent); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL %s_hold got %0d want 0", nm, hold_err); end
    endtask

    task automatic test_back_to_back();
        model_run(3, 3, 8'h10, 1'b1, 1, -1);
        do_start(3, 0, 3, 8'h10, 1'b1, 1);
        collect(200, 0, -1);
        checks++; if (got_q.size() != 9) begin errors++; $display("FAIL b2b_count got %0d want 9", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (low_cnt != 0) begin errors++; $display("FAIL b2b_gap got %0d want 0", low_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort(input int len, input int abort_at, input int mode);
        logic [7:0] seed;
        seed = 8'($urandom);
        model_run(len, 0, seed, 1'b0, 0, abort_at);
        do_start(len, 1, 0, seed, 1'b0, 0);
        collect(400, mode, abort_at);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL abort_timeout got 1 want 0"); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done got %0d want 1", done_cnt); end
        checks++; if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL abort_frames got %0d want %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_abort_gap();
        model_run(2, 0, 8'h40, 1'b0, 0, 1);
        do_start(2, 5, 0, 8'h40, 1'b0, 0);
        collect(200, 0, -2);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL agap_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL agap_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (low_cnt != 1) begin errors++; $display("FAIL agap_low got %0d want 1", low_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL agap_done got %0d want 1", done_cnt); end
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL agap_frames got %0d want 1", frames_sent); end
    endtask

    task automatic test_len_zero();
        int gap;
        gap = $urandom_range(0, 2);
        model_run(0, 2, 8'h7F, 1'b0, 0, -1);
        do_start(0, gap, 2, 8'h7F, 1'b0, 0);
        collect(200, 2, -1);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL len0_count got %0d want 2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL len0_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (frames_sent !== 16'd2) begin errors++; $display("FAIL len0_frames got %0d want 2", frames_sent); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seed;
        do_start(8, 0, 0, 8'hA0, 1'b0, 0);
        repeat (3) @(negedge clk);
        #2 async_rst_n = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got %b want 0", tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL rmid_tlast got %b want 0", tlast); end
        @(negedge clk);
        async_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rmid_resume got %b want 0", tvalid); end
        seed = 8'($urandom);
        model_run(8, 0, seed, 1'b0, 0, 1);
        do_start(8, 0, 0, seed, 1'b0, 0);
        collect(200, 0, 1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int len, gap, frames, err_idx;
        bit err_en;
        logic [7:0] seed;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(0, 5); gap = $urandom_range(0, 3);
            frames = $urandom_range(1, 3); err_idx = $urandom_range(0, 3);
            err_en = 1'($urandom); seed = 8'($urandom);
            model_run(len, frames, seed, err_en, err_idx, -1);
            do_start(len, gap, frames, seed, err_en, err_idx);
            collect(400, 2, -1);
            checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got 1 want 0", it); end
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_beat%0d got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            checks++; if (low_cnt != gap * (frames - 1)) begin errors++; $display("FAIL rnd%0d_gap got %0d want %0d", it, low_cnt, gap * (frames - 1)); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done got %0d want 1", it, done_cnt); end
            checks++; if (frames_sent !== 16'(frames)) begin errors++; $display("FAIL rnd%0d_frames got %0d want %0d", it, frames_sent, frames); end
            checks++; if (hold_err != 0) begin errors++; $display("FAIL rnd%0d_hold got %0d want 0", it, hold_err); end
        end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; tready = 1'b1;
        cfg_len = 16'd0; cfg_gap = 16'd0; cfg_frames = 16'd0; cfg_seed = 8'd0;
        cfg_err_en = 1'b0; cfg_err_idx = 16'd0;
        test_reset();
        test_basic(0, "basic");
        test_basic(1, "stall");
        test_back_to_back();
        test_abort(8, 2, 0);
        for (int k = 0; k < 3; k++) test_abort($urandom_range(1, 6), $urandom_range(0, 12), 2);
        test_abort_gap();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
